spi_master_shift: RTL and testbench

SPI master byte engine for the memory-mapped SPI peripheral. It sits directly downstream of the 100 kHz SCLK divider and consumes that divider's one-cycle rising and falling edge strobes. It generates `sclk_o`, `cs_o` and `mosi_o`, and samples `miso_i`, performing one N-bit mode-0 transfer (CPOL=0, CPHA=0, MSB first) per start request. Results are handed back to the peripheral register bank.

---
 rtl/spi_master_shift.sv | 160 ++++++++++++++++
 tb/tb_spi_master_shift.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_shift.sv
// Mode-0 SPI master byte engine driven by external SCLK edge strobes.
// Define SPI_LOOPBACK_EN to feed the rx shifter from mosi_o instead of miso_i.
module spi_master_shift #(
    parameter int N_BITS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flanco_pos_i,
    input  logic              flanco_neg_i,
    input  logic              start_i,
    input  logic [N_BITS-1:0] dato_tx_i,
    input  logic              miso_i,
    output logic              en_o,
    output logic              sclk_o,
    output logic              cs_o,
    output logic              mosi_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_BITS-1:0] dato_rx_o
);

    localparam int CW = $clog2(N_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [N_BITS-1:0] tx_q,      tx_d;
    logic [N_BITS-1:0] rx_q,      rx_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic              sclk_q,    sclk_d;
    logic              cs_q,      cs_d;
    logic              mosi_q,    mosi_d;
    logic              busy_q,    busy_d;
    logic              en_q,      en_d;
    logic              done_q,    done_d;
    logic [N_BITS-1:0] dato_rx_q, dato_rx_d;

    logic rx_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso_i;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit = miso_i;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        en_d      = en_q;
        done_d    = 1'b0;
        dato_rx_d = dato_rx_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    tx_d    = dato_tx_i;
                    rx_d    = '0;
                    cnt_d   = '0;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    en_d    = 1'b1;
                    mosi_d  = dato_tx_i[N_BITS-1];
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // A simultaneous rising strobe wins, so the falling one is dropped here too.
                if (flanco_neg_i && !flanco_pos_i) begin
                    state_d = ST_XFER;
                end
            end

            ST_XFER: begin
                if (flanco_pos_i) begin
                    sclk_d = 1'b1;
                    rx_d   = {rx_q[N_BITS-2:0], rx_bit};
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (flanco_neg_i) begin
                    sclk_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        tx_d   = {tx_q[N_BITS-2:0], 1'b0};
                        mosi_d = tx_q[N_BITS-2];
                    end
                end
            end

            ST_HOLD: begin
                if (flanco_pos_i) begin
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    en_d      = 1'b0;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    dato_rx_d = rx_q;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            done_q    <= 1'b0;
            dato_rx_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            en_q      <= en_d;
            done_q    <= done_d;
            dato_rx_q <= dato_rx_d;
        end
    end

    assign en_o      = en_q;
    assign sclk_o    = sclk_q;
    assign cs_o      = cs_q;
    assign mosi_o    = mosi_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign dato_rx_o = dato_rx_q;

endmodule

// File: tb/tb_spi_master_shift.sv
// Bench for spi_master_shift: divider and slave models, scoreboard of expected rx words,
// hand-driven strobe sequences for corner cases, and a 16-bit instance.
`timescale 1ns/1ps
module tb_spi_master_shift;

    localparam int DIV = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] dato_tx_i = 8'h00;
    logic       miso_i;
    logic       flanco_pos_i, flanco_neg_i;
    logic       en_o, sclk_o, cs_o, mosi_o, busy_o, done_o;
    logic [7:0] dato_rx_o;

    logic        start16 = 1'b0;
    logic [15:0] tx16 = 16'h0000;
    logic        p16 = 1'b0, n16 = 1'b0;
    logic        miso16;
    logic        en16, sclk16, cs16, mosi16, busy16, done16;
    logic [15:0] rx16;

    logic manual = 1'b0, man_pos = 1'b0, man_neg = 1'b0;
    logic div_pos = 1'b0, div_neg = 1'b0;
    int   div_cnt = 0;

    logic [7:0]  slave_word = 8'h00;
    logic [7:0]  slave_sr = 8'h00;
    logic [15:0] slave16_word = 16'hBEEF;
    logic [15:0] slave16_sr = 16'h0000;
    logic        cs_d1 = 1'b1, sclk_d1 = 1'b0, cs16_d1 = 1'b1, sclk16_d1 = 1'b0;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] sb_q[$];

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
    } vec_t;
    vec_t vecs[4];

    always #50 clk = ~clk;

    assign flanco_pos_i = manual ? man_pos : div_pos;
    assign flanco_neg_i = manual ? man_neg : div_neg;
    assign miso_i = slave_sr[7];
    assign miso16 = slave16_sr[15];

    spi_master_shift #(.N_BITS(8)) u_dut (
        .clk_i(clk), .rst_i(rst_n),
        .flanco_pos_i(flanco_pos_i), .flanco_neg_i(flanco_neg_i),
        .start_i(start_i), .dato_tx_i(dato_tx_i), .miso_i(miso_i),
        .en_o(en_o), .sclk_o(sclk_o), .cs_o(cs_o), .mosi_o(mosi_o),
        .busy_o(busy_o), .done_o(done_o), .dato_rx_o(dato_rx_o)
    );

    spi_master_shift #(.N_BITS(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst_n),
        .flanco_pos_i(p16), .flanco_neg_i(n16),
        .start_i(start16), .dato_tx_i(tx16), .miso_i(miso16),
        .en_o(en16), .sclk_o(sclk16), .cs_o(cs16), .mosi_o(mosi16),
        .busy_o(busy16), .done_o(done16), .dato_rx_o(rx16)
    );

    // SCLK divider model: rising strobe mid-period, falling strobe at period end.
    always @(negedge clk) begin
        if (!en_o) begin
            div_cnt = 0;
            div_pos = 1'b0;
            div_neg = 1'b0;
        end else begin
            div_cnt = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
            div_pos = (div_cnt == DIV / 2 - 1);
            div_neg = (div_cnt == DIV - 1);
        end
    end

    // Mode-0 slave models: load on CS fall, shift out after each SCLK fall.
    always @(posedge clk) begin
        cs_d1   <= cs_o;
        sclk_d1 <= sclk_o;
        if (cs_d1 && !cs_o) slave_sr <= slave_word;
        else if (sclk_d1 && !sclk_o) slave_sr <= {slave_sr[6:0], 1'b0};
        cs16_d1   <= cs16;
        sclk16_d1 <= sclk16;
        if (cs16_d1 && !cs16) slave16_sr <= slave16_word;
        else if (sclk16_d1 && !sclk16) slave16_sr <= {slave16_sr[14:0], 1'b0};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] tx, input logic [7:0] sw);
`ifdef SPI_LOOPBACK_EN
        return tx;
`else
        return sw;
`endif
    endfunction

    task automatic pulse(input logic p, input logic n);
        man_pos = p;
        man_neg = n;
        @(negedge clk);
        man_pos = 1'b0;
        man_neg = 1'b0;
    endtask

    task automatic pulse16(input logic p, input logic n);
        p16 = p;
        n16 = n;
        @(negedge clk);
        p16 = 1'b0;
        n16 = 1'b0;
    endtask

    // Runs one divider-paced transfer; returns at the negedge where done_o is seen.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] sw, input int inject_rise);
        int         rises = 0;
        int         lat = 1;
        logic       got = 1'b0;
        logic       injected = 1'b0;
        logic       prev;
        logic [7:0] bits = 8'h00;
        logic [7:0] exp;
        slave_word = sw;
        sb_q.push_back(exp_rx(tx, sw));
        dato_tx_i = tx;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        dato_tx_i = ~tx;
        check("done_one_cycle", done_o, 0);
        check("cs_low_after_start", cs_o, 0);
        check("busy_after_start", busy_o, 1);
        check("en_after_start", en_o, 1);
        check("mosi_msb_at_start", mosi_o, tx[7]);
        prev = sclk_o;
        while (lat < 1100 && !got) begin
            @(negedge clk);
            lat++;
            start_i = 1'b0;
            if (sclk_o && !prev) begin
                rises++;
                bits = {bits[6:0], mosi_o};
            end
            prev = sclk_o;
            if (inject_rise >= 0 && rises == inject_rise && !injected) begin
                injected = 1'b1;
                start_i = 1'b1;
                dato_tx_i = 8'h11;
            end
            if (done_o) got = 1'b1;
        end
        check("done_seen", got, 1);
        check("latency_le_1000", lat <= 1000, 1);
        check("sclk_rises", rises, 8);
        check("mosi_bits", bits, tx);
        check("cs_high_at_done", cs_o, 1);
        check("busy_low_at_done", busy_o, 0);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            exp = sb_q.pop_front();
            check("dato_rx", dato_rx_o, exp);
        end
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rises;
        int   extra;
        int   lat;
        logic prev;

        vecs[0] = '{tx: 8'hA5, slave: 8'h3C};
        vecs[1] = '{tx: 8'h00, slave: 8'hFF};
        vecs[2] = '{tx: 8'hFF, slave: 8'h00};
        vecs[3] = '{tx: 8'h5A, slave: 8'hC3};

        // Held in reset while strobes and start toggle.
        manual = 1'b1;
        start_i = 1'b1;
        dato_tx_i = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            man_pos = i[0];
            man_neg = ~i[0];
            @(negedge clk);
            check("rst_cs", cs_o, 1);
            check("rst_done", done_o, 0);
            check("rst_sclk", sclk_o, 0);
            check("rst_en", en_o, 0);
        end
        check("rst_rx", dato_rx_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_busy", busy_o, 0);
        man_pos = 1'b0;
        man_neg = 1'b0;
        start_i = 1'b0;
        manual = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Back-to-back transfers, each restarted the cycle after done_o.
        for (int i = 0; i < 4; i++) begin
            run_xfer(vecs[i].tx, vecs[i].slave, -1);
        end
        @(negedge clk);
        check("done_pulse_ends", done_o, 0);

        // Start request while busy must be ignored.
        run_xfer(8'hC3, 8'hA6, 2);
        extra = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done_o) extra++;
        end
        check("no_extra_done", extra, 0);
        check("idle_after_busy_start", busy_o, 0);

        // Asynchronous reset after three rising edges, applied between clock edges.
        slave_word = 8'h55;
        dato_tx_i = 8'hE7;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        rises = 0;
        lat = 0;
        prev = sclk_o;
        while (rises < 3 && lat < 1100) begin
            @(negedge clk);
            lat++;
            if (sclk_o && !prev) rises++;
            prev = sclk_o;
        end
        check("reached_three_rises", rises, 3);
        #10 rst_n = 1'b0;
        #1;
        check("async_rst_cs", cs_o, 1);
        check("async_rst_rx", dato_rx_o, 0);
        check("async_rst_sclk", sclk_o, 0);
        check("async_rst_busy", busy_o, 0);
        check("async_rst_en", en_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("no_done_after_abort", done_o, 0);
        run_xfer(8'h81, 8'h7E, -1);

        // Hand-driven strobes: rising ignored in SETUP, simultaneous strobes favour rising.
        repeat (3) @(negedge clk);
        manual = 1'b1;
        slave_word = 8'h69;
        dato_tx_i = 8'h96;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b0);
        check("setup_ignores_pos", sclk_o, 0);
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1);
        check("setup_to_xfer_sclk", sclk_o, 0);
        check("setup_mosi_msb", mosi_o, 1);
        repeat (2) @(negedge clk);
        pulse(1'b1, 1'b1);
        check("both_strobes_rise", sclk_o, 1);
        repeat (2) @(negedge clk);
        check("both_strobes_fall_dropped", sclk_o, 1);
        check("both_strobes_mosi_held", mosi_o, 1);
        pulse(1'b0, 1'b1);
        check("fall_after_both", sclk_o, 0);
        check("second_bit", mosi_o, 0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            pulse(1'b1, 1'b0);
            repeat (2) @(negedge clk);
            pulse(1'b0, 1'b1);
            repeat (2) @(negedge clk);
        end
        check("hold_sclk_low", sclk_o, 0);
        check("hold_no_done_yet", done_o, 0);
        check("hold_mosi_last_bit", mosi_o, 0);
        pulse(1'b1, 1'b0);
        check("manual_done", done_o, 1);
        check("manual_rx", dato_rx_o, exp_rx(8'h96, 8'h69));
        check("manual_hold_sclk", sclk_o, 0);
        @(negedge clk);
        check("manual_done_one_cycle", done_o, 0);
        check("idle_mosi_zero", mosi_o, 0);
        manual = 1'b0;

        // 16-bit instance driven by hand-made strobes.
        tx16 = 16'hBEEF;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        tx16 = 16'h0000;
        check("n16_cs_low", cs16, 0);
        repeat (2) @(negedge clk);
        pulse16(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        rises = 0;
        for (int i = 0; i < 16; i++) begin
            pulse16(1'b1, 1'b0);
            if (sclk16) rises++;
            repeat (2) @(negedge clk);
            pulse16(1'b0, 1'b1);
            repeat (2) @(negedge clk);
        end
        check("n16_rises", rises, 16);
        check("n16_no_early_done", done16, 0);
        pulse16(1'b1, 1'b0);
        check("n16_done", done16, 1);
        check("n16_rx", rx16, 16'hBEEF);
        check("n16_cs_high", cs16, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
